cubedma_ctrl_regs: RTL and testbench

AXI4-Lite responder that holds the cubedma control/status register file for the MM2S (read) and S2MM (write) channels. It decodes bus writes and reads from the host and drives each channel's transfer configuration and one-cycle start strobe. It collects busy/done from the channel engines and raises the per-channel interrupt. It sits between the `s_axi_ctrl_status_*` port of `cubedma_top` and the two DataMover sequencers.

---
 rtl/cubedma_pkg.sv | 57 +++++
 rtl/cubedma_chan_regs.sv | 97 +++++++++
 rtl/cubedma_ctrl_regs.sv | 203 ++++++++++++++++++++
 tb/tb_cubedma_ctrl_regs.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cubedma_pkg.sv
// cubedma control/status register file: shared types and constants.
// Register offsets, bit positions, response codes and channel config.
package cubedma_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_SIZE   = 5'h0C;
  localparam logic [4:0] OFF_BLOCK  = 5'h10;
  localparam logic [4:0] OFF_LSKIP  = 5'h14;

  localparam int CTRL_START      = 0;
  localparam int CTRL_MODE_BLOCK = 2;
  localparam int CTRL_MODE_PLANE = 3;
  localparam int CTRL_IRQ_EN     = 5;
  localparam int CTRL_OFFSET     = 16;
  localparam int STAT_BUSY       = 0;
  localparam int STAT_DONE       = 5;

  // Writable bits; everything else is reserved and reads 0.
  localparam logic [31:0] CTRL_MASK  = 32'h0001_FF2C;
  localparam logic [31:0] BLOCK_MASK = 32'hFFFF_F0FF;
  localparam logic [31:0] LSKIP_MASK = 32'h000F_FFFF;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wstate_t;
  typedef enum logic { R_IDLE, R_DATA } rstate_t;

  typedef struct packed {
    logic [11:0] width;
    logic [11:0] height;
    logic [7:0]  depth;
    logic [3:0]  block_width;
    logic [3:0]  block_height;
    logic [19:0] last_block_row_length;
    logic [19:0] line_skip;
    logic        mode_block;
    logic        mode_plane;
    logic        offset;
    logic [7:0]  plane_transfers;
  } cubedma_cfg_t;

  function automatic logic [31:0] apply_strb(
    input logic [31:0] old,
    input logic [31:0] data,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? data[i*8 +: 8]
                              : old[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cubedma_chan_regs.sv
// One channel bank: config registers, DONE/IRQ and start strobe.
// Config writes are refused while the channel engine is busy.
module cubedma_chan_regs
  import cubedma_pkg::*;
(
  input  logic         clk,
  input  logic         aresetn,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic [3:0]   wr_strb,
  output logic         wr_err,
  input  logic [4:0]   rd_addr,
  output logic [31:0]  rd_data,
  input  logic         busy,
  input  logic         done,
  output cubedma_cfg_t cfg,
  output logic         start,
  output logic         irq
);

  logic [31:0] ctrl_q, size_q, block_q, lskip_q;
  logic        done_q, start_q;
  logic        hit_ctrl, hit_stat, hit_size;
  logic        hit_block, hit_lskip, w1c, upd;

  always_comb begin
    hit_ctrl  = wr_en && (wr_addr == OFF_CTRL);
    hit_stat  = wr_en && (wr_addr == OFF_STATUS);
    hit_size  = wr_en && (wr_addr == OFF_SIZE);
    hit_block = wr_en && (wr_addr == OFF_BLOCK);
    hit_lskip = wr_en && (wr_addr == OFF_LSKIP);
    upd       = !busy;
    wr_err    = busy && (hit_ctrl || hit_size ||
                         hit_block || hit_lskip);
    w1c       = hit_stat && wr_strb[0] &&
                wr_data[STAT_DONE];
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      ctrl_q  <= '0;
      size_q  <= '0;
      block_q <= '0;
      lskip_q <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      if (hit_ctrl && upd)
        ctrl_q <= apply_strb(ctrl_q, wr_data, wr_strb)
                  & CTRL_MASK;
      if (hit_size && upd)
        size_q <= apply_strb(size_q, wr_data, wr_strb);
      if (hit_block && upd)
        block_q <= apply_strb(block_q, wr_data, wr_strb)
                   & BLOCK_MASK;
      if (hit_lskip && upd)
        lskip_q <= apply_strb(lskip_q, wr_data, wr_strb)
                   & LSKIP_MASK;
      start_q <= hit_ctrl && upd && wr_strb[0] &&
                 wr_data[CTRL_START];
      // A completion in the same cycle as a clear wins.
      done_q  <= done || (done_q && !w1c);
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (rd_addr)
      OFF_CTRL:  rd_data = ctrl_q;
      OFF_STATUS: begin
        rd_data[STAT_BUSY] = busy;
        rd_data[STAT_DONE] = done_q;
      end
      OFF_SIZE:  rd_data = size_q;
      OFF_BLOCK: rd_data = block_q;
      OFF_LSKIP: rd_data = lskip_q;
      default:   rd_data = '0;
    endcase
  end

  assign cfg.width                 = size_q[11:0];
  assign cfg.height                = size_q[23:12];
  assign cfg.depth                 = size_q[31:24];
  assign cfg.block_width           = block_q[3:0];
  assign cfg.block_height          = block_q[7:4];
  assign cfg.last_block_row_length = block_q[31:12];
  assign cfg.line_skip             = lskip_q[19:0];
  assign cfg.mode_block            = ctrl_q[CTRL_MODE_BLOCK];
  assign cfg.mode_plane            = ctrl_q[CTRL_MODE_PLANE];
  assign cfg.offset                = ctrl_q[CTRL_OFFSET];
  assign cfg.plane_transfers       = ctrl_q[15:8];

  assign start = start_q;
  assign irq   = done_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/cubedma_ctrl_regs.sv
// AXI4-Lite responder for the cubedma MM2S/S2MM register banks.
// Writes may pile up unanswered up to C_MAX_OUTSTANDING_B responses.
module cubedma_ctrl_regs
  import cubedma_pkg::*;
#(
  parameter int C_ADDR_WIDTH        = 6,
  parameter int C_MAX_OUTSTANDING_B = 15
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [C_ADDR_WIDTH-1:0] s_axi_ctrl_status_awaddr,
  input  logic [2:0]              s_axi_ctrl_status_awprot,
  input  logic                    s_axi_ctrl_status_awvalid,
  output logic                    s_axi_ctrl_status_awready,
  input  logic [31:0]             s_axi_ctrl_status_wdata,
  input  logic [3:0]              s_axi_ctrl_status_wstrb,
  input  logic                    s_axi_ctrl_status_wvalid,
  output logic                    s_axi_ctrl_status_wready,
  output logic [1:0]              s_axi_ctrl_status_bresp,
  output logic                    s_axi_ctrl_status_bvalid,
  input  logic                    s_axi_ctrl_status_bready,
  input  logic [C_ADDR_WIDTH-1:0] s_axi_ctrl_status_araddr,
  input  logic [2:0]              s_axi_ctrl_status_arprot,
  input  logic                    s_axi_ctrl_status_arvalid,
  output logic                    s_axi_ctrl_status_arready,
  output logic [31:0]             s_axi_ctrl_status_rdata,
  output logic [1:0]              s_axi_ctrl_status_rresp,
  output logic                    s_axi_ctrl_status_rvalid,
  input  logic                    s_axi_ctrl_status_rready,
  output logic                    mm2s_start,
  output logic [11:0]             mm2s_cfg_width,
  output logic [11:0]             mm2s_cfg_height,
  output logic [7:0]              mm2s_cfg_depth,
  output logic [3:0]              mm2s_cfg_block_width,
  output logic [3:0]              mm2s_cfg_block_height,
  output logic [19:0]             mm2s_cfg_last_block_row_length,
  output logic [19:0]             mm2s_cfg_line_skip,
  output logic                    mm2s_cfg_mode_block,
  output logic                    mm2s_cfg_mode_plane,
  output logic                    mm2s_cfg_offset,
  output logic [7:0]              mm2s_cfg_plane_transfers,
  input  logic                    mm2s_busy,
  input  logic                    mm2s_done,
  output logic                    mm2s_irq,
  output logic                    s2mm_start,
  output logic [11:0]             s2mm_cfg_width,
  output logic [11:0]             s2mm_cfg_height,
  output logic [7:0]              s2mm_cfg_depth,
  output logic [3:0]              s2mm_cfg_block_width,
  output logic [3:0]              s2mm_cfg_block_height,
  output logic [19:0]             s2mm_cfg_last_block_row_length,
  output logic [19:0]             s2mm_cfg_line_skip,
  output logic                    s2mm_cfg_mode_block,
  output logic                    s2mm_cfg_mode_plane,
  output logic                    s2mm_cfg_offset,
  output logic [7:0]              s2mm_cfg_plane_transfers,
  input  logic                    s2mm_busy,
  input  logic                    s2mm_done,
  output logic                    s2mm_irq
);

  localparam int BW = $clog2(C_MAX_OUTSTANDING_B + 1);
  localparam logic [BW-1:0] BMAX = BW'(C_MAX_OUTSTANDING_B);
  localparam int BANK = C_ADDR_WIDTH - 1;

  wstate_t      wstate, wstate_n;
  rstate_t      rstate, rstate_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic         err_q, err_n;
  logic         live, acc, bhs, acc_err;
  logic         err0, err1;
  logic [31:0]  rd0, rd1, rdata_q;
  cubedma_cfg_t cfg0, cfg1;
  logic         unused;

  assign unused = ^{s_axi_ctrl_status_awprot,
                    s_axi_ctrl_status_arprot};

  // Holds the handshakes low for the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (!aresetn) live <= 1'b0;
    else          live <= 1'b1;
  end

  assign acc = live && s_axi_ctrl_status_awvalid &&
               s_axi_ctrl_status_wvalid && (bcnt < BMAX);
  assign s_axi_ctrl_status_awready = acc;
  assign s_axi_ctrl_status_wready  = acc;
  assign s_axi_ctrl_status_bvalid  = (wstate == W_RESP);
  assign s_axi_ctrl_status_bresp   = err_q ? RESP_SLVERR
                                           : RESP_OKAY;
  assign bhs     = s_axi_ctrl_status_bvalid &&
                   s_axi_ctrl_status_bready;
  assign acc_err = err0 || err1;

  always_comb begin
    bcnt_n = bcnt;
    err_n  = err_q || (acc && acc_err);
    if (acc && !bhs)      bcnt_n = bcnt + BW'(1);
    else if (!acc && bhs) bcnt_n = bcnt - BW'(1);
    if (bcnt_n == '0) err_n = 1'b0;
    wstate_n = (bcnt_n != '0) ? W_RESP : W_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wstate <= W_IDLE;
      bcnt   <= '0;
      err_q  <= 1'b0;
    end else begin
      wstate <= wstate_n;
      bcnt   <= bcnt_n;
      err_q  <= err_n;
    end
  end

  assign s_axi_ctrl_status_arready = live && (rstate == R_IDLE);
  assign s_axi_ctrl_status_rvalid  = (rstate == R_DATA);
  assign s_axi_ctrl_status_rdata   = rdata_q;
  assign s_axi_ctrl_status_rresp   = RESP_OKAY;

  always_comb begin
    rstate_n = rstate;
    unique case (rstate)
      R_IDLE: if (s_axi_ctrl_status_arready &&
                  s_axi_ctrl_status_arvalid)
                rstate_n = R_DATA;
      R_DATA: if (s_axi_ctrl_status_rready)
                rstate_n = R_IDLE;
      default: rstate_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rstate  <= R_IDLE;
      rdata_q <= '0;
    end else begin
      rstate <= rstate_n;
      if (s_axi_ctrl_status_arready && s_axi_ctrl_status_arvalid)
        rdata_q <= s_axi_ctrl_status_araddr[BANK] ? rd1 : rd0;
    end
  end

  cubedma_chan_regs u_mm2s (
    .clk     (clk),
    .aresetn (aresetn),
    .wr_en   (acc && !s_axi_ctrl_status_awaddr[BANK]),
    .wr_addr (s_axi_ctrl_status_awaddr[4:0]),
    .wr_data (s_axi_ctrl_status_wdata),
    .wr_strb (s_axi_ctrl_status_wstrb),
    .wr_err  (err0),
    .rd_addr (s_axi_ctrl_status_araddr[4:0]),
    .rd_data (rd0),
    .busy    (mm2s_busy),
    .done    (mm2s_done),
    .cfg     (cfg0),
    .start   (mm2s_start),
    .irq     (mm2s_irq)
  );

  cubedma_chan_regs u_s2mm (
    .clk     (clk),
    .aresetn (aresetn),
    .wr_en   (acc && s_axi_ctrl_status_awaddr[BANK]),
    .wr_addr (s_axi_ctrl_status_awaddr[4:0]),
    .wr_data (s_axi_ctrl_status_wdata),
    .wr_strb (s_axi_ctrl_status_wstrb),
    .wr_err  (err1),
    .rd_addr (s_axi_ctrl_status_araddr[4:0]),
    .rd_data (rd1),
    .busy    (s2mm_busy),
    .done    (s2mm_done),
    .cfg     (cfg1),
    .start   (s2mm_start),
    .irq     (s2mm_irq)
  );

  assign mm2s_cfg_width                 = cfg0.width;
  assign mm2s_cfg_height                = cfg0.height;
  assign mm2s_cfg_depth                 = cfg0.depth;
  assign mm2s_cfg_block_width           = cfg0.block_width;
  assign mm2s_cfg_block_height          = cfg0.block_height;
  assign mm2s_cfg_last_block_row_length = cfg0.last_block_row_length;
  assign mm2s_cfg_line_skip             = cfg0.line_skip;
  assign mm2s_cfg_mode_block            = cfg0.mode_block;
  assign mm2s_cfg_mode_plane            = cfg0.mode_plane;
  assign mm2s_cfg_offset                = cfg0.offset;
  assign mm2s_cfg_plane_transfers       = cfg0.plane_transfers;

  assign s2mm_cfg_width                 = cfg1.width;
  assign s2mm_cfg_height                = cfg1.height;
  assign s2mm_cfg_depth                 = cfg1.depth;
  assign s2mm_cfg_block_width           = cfg1.block_width;
  assign s2mm_cfg_block_height          = cfg1.block_height;
  assign s2mm_cfg_last_block_row_length = cfg1.last_block_row_length;
  assign s2mm_cfg_line_skip             = cfg1.line_skip;
  assign s2mm_cfg_mode_block            = cfg1.mode_block;
  assign s2mm_cfg_mode_plane            = cfg1.mode_plane;
  assign s2mm_cfg_offset                = cfg1.offset;
  assign s2mm_cfg_plane_transfers       = cfg1.plane_transfers;

endmodule

// File: tb/tb_cubedma_ctrl_regs.sv
// Bench for cubedma_ctrl_regs: register-file model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_cubedma_ctrl_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;

  logic [11:0] o_w[2], o_h[2];
  logic [7:0]  o_d[2], o_pt[2];
  logic [3:0]  o_bw[2], o_bh[2];
  logic [19:0] o_lb[2], o_ls[2];
  logic        o_mb[2], o_mp[2], o_off[2], o_st[2], o_irq[2];
  logic        busy_in[2], done_in[2];

  int checks = 0;
  int errors = 0;
  int n_start[2] = '{0, 0};

  cubedma_ctrl_regs dut (
    .clk(clk), .aresetn(aresetn),
    .s_axi_ctrl_status_awaddr(awaddr),
    .s_axi_ctrl_status_awprot(awprot),
    .s_axi_ctrl_status_awvalid(awvalid),
    .s_axi_ctrl_status_awready(awready),
    .s_axi_ctrl_status_wdata(wdata),
    .s_axi_ctrl_status_wstrb(wstrb),
    .s_axi_ctrl_status_wvalid(wvalid),
    .s_axi_ctrl_status_wready(wready),
    .s_axi_ctrl_status_bresp(bresp),
    .s_axi_ctrl_status_bvalid(bvalid),
    .s_axi_ctrl_status_bready(bready),
    .s_axi_ctrl_status_araddr(araddr),
    .s_axi_ctrl_status_arprot(arprot),
    .s_axi_ctrl_status_arvalid(arvalid),
    .s_axi_ctrl_status_arready(arready),
    .s_axi_ctrl_status_rdata(rdata),
    .s_axi_ctrl_status_rresp(rresp),
    .s_axi_ctrl_status_rvalid(rvalid),
    .s_axi_ctrl_status_rready(rready),
    .mm2s_start(o_st[0]),
    .mm2s_cfg_width(o_w[0]), .mm2s_cfg_height(o_h[0]),
    .mm2s_cfg_depth(o_d[0]),
    .mm2s_cfg_block_width(o_bw[0]),
    .mm2s_cfg_block_height(o_bh[0]),
    .mm2s_cfg_last_block_row_length(o_lb[0]),
    .mm2s_cfg_line_skip(o_ls[0]),
    .mm2s_cfg_mode_block(o_mb[0]),
    .mm2s_cfg_mode_plane(o_mp[0]),
    .mm2s_cfg_offset(o_off[0]),
    .mm2s_cfg_plane_transfers(o_pt[0]),
    .mm2s_busy(busy_in[0]), .mm2s_done(done_in[0]),
    .mm2s_irq(o_irq[0]),
    .s2mm_start(o_st[1]),
    .s2mm_cfg_width(o_w[1]), .s2mm_cfg_height(o_h[1]),
    .s2mm_cfg_depth(o_d[1]),
    .s2mm_cfg_block_width(o_bw[1]),
    .s2mm_cfg_block_height(o_bh[1]),
    .s2mm_cfg_last_block_row_length(o_lb[1]),
    .s2mm_cfg_line_skip(o_ls[1]),
    .s2mm_cfg_mode_block(o_mb[1]),
    .s2mm_cfg_mode_plane(o_mp[1]),
    .s2mm_cfg_offset(o_off[1]),
    .s2mm_cfg_plane_transfers(o_pt[1]),
    .s2mm_busy(busy_in[1]), .s2mm_done(done_in[1]),
    .s2mm_irq(o_irq[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h want 0x%0h",
               nm, $time, act, exp);
    end
  endtask

  // Model: registers as words [ctrl,size,block,lskip] per bank.
  bit [31:0] m_reg [2][4];
  bit        m_done[2], m_start[2];
  int        m_pend;
  bit        m_err, m_live, m_rbusy;
  bit [31:0] m_rdata;

  function automatic int reg_idx(input logic [4:0] off);
    case (off)
      5'h00: return 0;
      5'h0C: return 1;
      5'h10: return 2;
      5'h14: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit [31:0] mask_of(input int idx);
    case (idx)
      0: return 32'h0001_FF2C;
      2: return 32'hFFFF_F0FF;
      3: return 32'h000F_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic bit [31:0] m_read(input bit b,
                                       input logic [4:0] off);
    int idx;
    idx = reg_idx(off);
    if (off == 5'h04)
      return (32'(m_done[b]) << 5) | 32'(busy_in[b]);
    if (idx >= 0) return m_reg[b][idx];
    return 0;
  endfunction

  always @(posedge clk) begin : model
    bit acc, bhs, w1c, bk;
    int idx;
    bit [31:0] nv;
    if (!aresetn) begin
      foreach (m_reg[i, j]) m_reg[i][j] = 0;
      m_done = '{0, 0};
      m_start = '{0, 0};
      m_pend = 0; m_err = 0; m_live = 0;
      m_rbusy = 0; m_rdata = 0;
    end else begin
      acc = awvalid && wvalid && m_live && (m_pend < 15);
      bhs = (m_pend != 0) && bready;
      if (!m_rbusy) begin
        if (arvalid && m_live) begin
          m_rdata = m_read(araddr[5], araddr[4:0]);
          m_rbusy = 1;
        end
      end else if (rready) m_rbusy = 0;
      for (int b = 0; b < 2; b++) begin
        w1c = acc && (int'(awaddr[5]) == b) &&
              (awaddr[4:0] == 5'h04) && wstrb[0] && wdata[5];
        m_done[b] = done_in[b] || (m_done[b] && !w1c);
        m_start[b] = 0;
      end
      if (acc) begin
        bk = awaddr[5];
        idx = reg_idx(awaddr[4:0]);
        if (idx >= 0 && busy_in[bk]) m_err = 1;
        else if (idx >= 0) begin
          nv = m_reg[bk][idx];
          for (int i = 0; i < 4; i++)
            if (wstrb[i]) nv[i*8 +: 8] = wdata[i*8 +: 8];
          m_reg[bk][idx] = nv & mask_of(idx);
          if (idx == 0 && wstrb[0] && wdata[0]) m_start[bk] = 1;
        end
      end
      m_pend = m_pend + int'(acc) - int'(bhs);
      if (m_pend == 0) m_err = 0;
      m_live = 1;
    end
  end

  always @(negedge clk) begin : compare
    bit exp_acc;
    exp_acc = awvalid && wvalid && m_live && (m_pend < 15);
    chk("awready", awready, exp_acc);
    chk("wready", wready, exp_acc);
    chk("arready", arready, m_live && !m_rbusy);
    chk("bvalid", bvalid, m_pend != 0);
    if (m_pend != 0) chk("bresp", bresp, {m_err, 1'b0});
    chk("rvalid", rvalid, m_rbusy);
    if (m_rbusy) begin
      chk("rdata", rdata, m_rdata);
      chk("rresp", rresp, 0);
    end
    for (int b = 0; b < 2; b++) begin
      if (o_st[b] === 1'b1) n_start[b]++;
      chk($sformatf("start%0d", b), o_st[b], m_start[b]);
      chk($sformatf("irq%0d", b), o_irq[b],
          m_done[b] && m_reg[b][0][5]);
      chk($sformatf("width%0d", b), o_w[b], m_reg[b][1][11:0]);
      chk($sformatf("height%0d", b), o_h[b], m_reg[b][1][23:12]);
      chk($sformatf("depth%0d", b), o_d[b], m_reg[b][1][31:24]);
      chk($sformatf("bw%0d", b), o_bw[b], m_reg[b][2][3:0]);
      chk($sformatf("bh%0d", b), o_bh[b], m_reg[b][2][7:4]);
      chk($sformatf("lbrl%0d", b), o_lb[b], m_reg[b][2][31:12]);
      chk($sformatf("lskip%0d", b), o_ls[b], m_reg[b][3][19:0]);
      chk($sformatf("mblk%0d", b), o_mb[b], m_reg[b][0][2]);
      chk($sformatf("mpln%0d", b), o_mp[b], m_reg[b][0][3]);
      chk($sformatf("offs%0d", b), o_off[b], m_reg[b][0][16]);
      chk($sformatf("ptx%0d", b), o_pt[b], m_reg[b][0][15:8]);
    end
  end

  task automatic axi_write(input logic [5:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = awready && wready;
    end
    if (!ok) chk("write_timeout", 0, 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
  endtask

  task automatic axi_read(input logic [5:0] a, input int hold,
                          output logic [31:0] d,
                          output logic [1:0] r);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1; rready = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = arready;
    end
    if (!ok) chk("ar_timeout", 0, 1);
    @(posedge clk); #1;
    arvalid = 0;
    repeat (hold) @(posedge clk);
    #1 rready = 1;
    ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = rvalid;
    end
    if (!ok) chk("r_timeout", 0, 1);
    d = rdata; r = rresp;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    bready = 1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = !bvalid;
    end
    chk("drain_bvalid", bvalid, 0);
  endtask

  logic [31:0] rd;
  logic [1:0]  rr;

  initial begin
    #200000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1);
  end

  initial begin
    aresetn = 0; awprot = 0; arprot = 0;
    awaddr = 6'h3C; araddr = 6'h3C;
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; arvalid = 1;
    bready = 1; rready = 0;
    busy_in = '{0, 0}; done_in = '{0, 0};
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_s2mm_width", o_w[1], 0);
    @(posedge clk); #1;
    aresetn = 1;
    @(negedge clk);
    chk("rst_rise_awready", awready, 0);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;

    // Bank 1 size then start with IRQ enabled.
    axi_write(6'h2C, 32'h0A00_A00A, 4'hF);
    axi_write(6'h20, 32'h0000_0021, 4'hF);
    chk("s2mm_width", o_w[1], 12'd10);
    chk("s2mm_height", o_h[1], 12'd10);
    chk("s2mm_depth", o_d[1], 8'd10);
    repeat (3) @(posedge clk);
    chk("s2mm_start_count", n_start[1], 1);
    chk("mm2s_start_count", n_start[0], 0);

    // Byte strobes and reserved bits on bank 0.
    axi_write(6'h0C, 32'hFFFF_FFFF, 4'b0101);
    chk("strb_width", o_w[0], 12'h0FF);
    chk("strb_height", o_h[0], 12'hFF0);
    chk("strb_depth", o_d[0], 8'h00);
    axi_write(6'h10, 32'hFFFF_FFFF, 4'hF);
    chk("block_lbrl", o_lb[0], 20'hFFFFF);
    axi_read(6'h10, 0, rd, rr);
    chk("block_readback", rd, 32'hFFFF_F0FF);
    axi_write(6'h00, 32'h0001_AB0D, 4'hF);
    chk("ctrl_ptx", o_pt[0], 8'hAB);
    chk("ctrl_offset", o_off[0], 1);
    axi_read(6'h00, 0, rd, rr);
    chk("ctrl_readback", rd, 32'h0001_AB0C);
    chk("mm2s_start_pulse", n_start[0], 1);

    // Unanswered writes pile up until the counter saturates.
    bready = 0;
    for (int i = 1; i <= 13; i++)
      axi_write(6'h14, 32'hABC0_0000 | i, 4'hF);
    @(negedge clk);
    chk("bcnt13_bvalid", bvalid, 1);
    chk("bcnt13_pend", m_pend, 13);
    axi_write(6'h14, 32'hABC0_000E, 4'hF);
    axi_write(6'h14, 32'hABC0_000F, 4'hF);
    @(posedge clk); #1;
    awaddr = 6'h14; wdata = 32'hFFF5_4321; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_awready", awready, 0);
    end
    @(posedge clk); #1 bready = 1;
    @(posedge clk); #1 bready = 0;
    @(negedge clk);
    chk("resume_awready", awready, 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    drain();
    chk("lskip_last", o_ls[0], 20'h54321);

    // Config writes are refused while the engine is busy.
    busy_in[1] = 1;
    axi_write(6'h20, 32'h0001_0F2D, 4'hF);
    @(negedge clk);
    chk("busy_bvalid", bvalid, 1);
    chk("busy_bresp", bresp, 2'b10);
    axi_write(6'h24, 32'h0000_0000, 4'hF);
    @(negedge clk);
    chk("busy_status_bresp", bresp, 2'b00);
    axi_read(6'h24, 0, rd, rr);
    chk("busy_status_read", rd, 32'h1);
    busy_in[1] = 0;
    axi_read(6'h20, 0, rd, rr);
    chk("busy_ctrl_unchanged", rd, 32'h20);
    chk("busy_no_start", n_start[1], 1);

    // DONE/IRQ: set, clear with read in the same cycle, collision.
    @(posedge clk); #1 done_in[1] = 1;
    @(posedge clk); #1 done_in[1] = 0;
    @(negedge clk);
    chk("irq_set", o_irq[1], 1);
    @(posedge clk); #1;
    awaddr = 6'h24; wdata = 32'h20; wstrb = 4'h1;
    awvalid = 1; wvalid = 1;
    araddr = 6'h24; arvalid = 1;
    @(negedge clk);
    chk("w1c_accept", awready, 1);
    chk("w1c_read_accept", arready, 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    chk("irq_cleared", o_irq[1], 0);
    chk("status_preclear", rdata, 32'h20);
    @(posedge clk); #1 rready = 1;
    @(posedge clk); #1 rready = 0;
    done_in[1] = 1;
    @(posedge clk); #1 done_in[1] = 0;
    @(negedge clk);
    chk("irq_set2", o_irq[1], 1);
    @(posedge clk); #1;
    awaddr = 6'h24; wdata = 32'h20; wstrb = 4'h1;
    awvalid = 1; wvalid = 1; done_in[1] = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; done_in[1] = 0;
    @(negedge clk);
    chk("irq_set_wins", o_irq[1], 1);
    axi_write(6'h24, 32'h20, 4'h1);
    @(negedge clk);
    chk("irq_final_clear", o_irq[1], 0);

    // Held read data and unmapped offset.
    axi_read(6'h2C, 3, rd, rr);
    chk("size_read", rd, 32'h0A00_A00A);
    chk("size_rresp", rr, 2'b00);
    axi_read(6'h3C, 3, rd, rr);
    chk("unmapped_read", rd, 32'h0);
    chk("unmapped_rresp", rr, 2'b00);

    // Reset drops a pending response.
    bready = 0;
    axi_write(6'h3C, 32'h1, 4'hF);
    @(negedge clk);
    chk("pending_before_rst", bvalid, 1);
    @(posedge clk); #1 aresetn = 0;
    @(posedge clk); #1 aresetn = 1;
    @(negedge clk);
    chk("rst_drops_b", bvalid, 0);
    chk("rst_clears_cfg", o_w[1], 0);
    bready = 1;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
